// File: rtl/sync_fifo_if.sv
// -----------------------------------------------------------------------------
// sync_fifo_if: bundle of the producer/consumer-facing signals of sync_fifo.
//
// Signals:
//   wr           write request, w_data is pushed when accepted
//   w_data       write data (DATA_WIDTH)
//   rd           read request, pops the word currently shown on r_data
//   r_data       head word (first-word-fall-through), 0 when empty
//   empty/full   occupancy flags
//   almost_empty count <= ALMOST_EMPTY_THRESH
//   almost_full  count >= ALMOST_FULL_THRESH
//   word_count   stored words, zero-extended to ADDR_WIDTH+2 bits
//   overflow     sticky dropped-write flag (only with FIFO_ERR_FLAGS_EN)
//   underflow    sticky empty-read flag   (only with FIFO_ERR_FLAGS_EN)
//
// Handshake: wr and rd are requests, and full/empty act as the
// inverse of ready. A write is taken on a rising edge when
// wr & (~full | rd). A read is taken when rd & ~empty. Requests that are not
// taken are dropped, not held; the requester must retry.
//
// Modports: master = producer/consumer side, slave = the FIFO.
// Macro: FIFO_ERR_FLAGS_EN adds overflow/underflow.
// -----------------------------------------------------------------------------
interface sync_fifo_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4
);
    logic                  wr;
    logic [DATA_WIDTH-1:0] w_data;
    logic                  rd;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  empty;
    logic                  full;
    logic                  almost_empty;
    logic                  almost_full;
    logic [ADDR_WIDTH+1:0] word_count;
`ifdef FIFO_ERR_FLAGS_EN
    logic                  overflow;
    logic                  underflow;

    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full, almost_empty, almost_full, word_count,
               overflow, underflow
    );
    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full, almost_empty, almost_full, word_count,
               overflow, underflow
    );
`else
    modport master (
        output wr, w_data, rd,
        input  r_data, empty, full, almost_empty, almost_full, word_count
    );
    modport slave (
        input  wr, w_data, rd,
        output r_data, empty, full, almost_empty, almost_full, word_count
    );
`endif
endinterface

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo: single-clock FIFO of 2^ADDR_WIDTH words of DATA_WIDTH bits with
// first-word-fall-through read data and occupancy flags.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset; clears pointers and count, and
//          discards stored data (memory array itself is not cleared)
//   fifo   sync_fifo_if.slave: wr/w_data/rd in; r_data, empty, full,
//          almost_empty, almost_full, word_count out
//          (+ overflow/underflow when FIFO_ERR_FLAGS_EN is defined)
//
// Optional feature macro: FIFO_ERR_FLAGS_EN (sticky overflow/underflow).
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int DATA_WIDTH          = 8,
    parameter int ADDR_WIDTH          = 4,
    parameter int ALMOST_EMPTY_THRESH = 1,
    parameter int ALMOST_FULL_THRESH  = (1 << ADDR_WIDTH) - 1
) (
    input  logic       clk,
    input  logic       reset,
    sync_fifo_if.slave fifo
);
    localparam int DEPTH = 1 << ADDR_WIDTH;
    // Count needs one more bit than the pointers to represent DEPTH itself.
    localparam int CW = ADDR_WIDTH + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AE_C    = CW'(ALMOST_EMPTY_THRESH);
    localparam logic [CW-1:0] AF_C    = CW'(ALMOST_FULL_THRESH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rptr;
    logic [CW-1:0]         count;

    logic is_empty;
    logic is_full;
    logic wr_ok;
    logic rd_ok;

    assign is_empty = (count == '0);
    assign is_full  = (count == DEPTH_C);

    // A full FIFO still takes a write when the head is popped on the same edge.
    assign wr_ok = fifo.wr & (~is_full | fifo.rd);
    assign rd_ok = fifo.rd & ~is_empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wptr <= wptr + 1'b1;
            if (rd_ok) rptr <= rptr + 1'b1;
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage has no reset; a write coinciding with reset is discarded.
    always_ff @(posedge clk) begin
        if (wr_ok && !reset) mem[wptr] <= fifo.w_data;
    end

    assign fifo.r_data       = is_empty ? '0 : mem[rptr];
    assign fifo.empty        = is_empty;
    assign fifo.full         = is_full;
    assign fifo.almost_empty = (count <= AE_C);
    assign fifo.almost_full  = (count >= AF_C);
    assign fifo.word_count   = {1'b0, count};

`ifdef FIFO_ERR_FLAGS_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (fifo.wr && is_full && !fifo.rd) overflow_q  <= 1'b1;
            if (fifo.rd && is_empty)            underflow_q <= 1'b1;
        end
    end

    assign fifo.overflow  = overflow_q;
    assign fifo.underflow = underflow_q;
`endif
endmodule

// File: tb/tb_sync_fifo.sv
// -----------------------------------------------------------------------------
// tb_sync_fifo: directed self-checking bench for sync_fifo with
// DATA_WIDTH=4, ADDR_WIDTH=4 (DEPTH=16). Inputs change 1ns after each rising
// edge and outputs are sampled there, away from the active edge.
// -----------------------------------------------------------------------------
module tb_sync_fifo;
    localparam int DW = 4;
    localparam int AW = 4;

    logic clk;
    logic reset;
    int   tests;
    int   fails;

    sync_fifo_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sync_fifo #(
        .DATA_WIDTH(DW),
        .ADDR_WIDTH(AW)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .fifo (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and land 1ns past the edge.
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr     = 1'b0;
        bus.rd     = 1'b0;
        bus.w_data = '0;
    endtask

    task automatic do_reset();
        idle();
        reset = 1'b1;
        cyc();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        tests++;
        if ({bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== 4'b1010) begin
            fails++;
            $display("FAIL reset_flags: got e/f/ae/af=%b expected 1010",
                     {bus.empty, bus.full, bus.almost_empty, bus.almost_full});
        end
        tests++;
        if (bus.word_count !== 6'd0 || bus.r_data !== 4'd0) begin
            fails++;
            $display("FAIL reset_count_data: got count=%0d r_data=%0d expected 0/0",
                     bus.word_count, bus.r_data);
        end
`ifdef FIFO_ERR_FLAGS_EN
        tests++;
        if ({bus.overflow, bus.underflow} !== 2'b00) begin
            fails++;
            $display("FAIL reset_err: got ovf/unf=%b expected 00", {bus.overflow, bus.underflow});
        end
`endif
    endtask

    task automatic test_fill();
        logic [3:0] exp_flags;
        do_reset();
        for (int i = 0; i < 16; i++) begin
            bus.wr     = 1'b1;
            bus.w_data = 4'(i);
            cyc();
            // e, f, ae, af for count i+1
            exp_flags = {1'b0, (i + 1 == 16), (i + 1 <= 1), (i + 1 >= 15)};
            tests++;
            if (bus.word_count !== 6'(i + 1) || bus.r_data !== 4'd0 ||
                {bus.empty, bus.full, bus.almost_empty, bus.almost_full} !== exp_flags) begin
                fails++;
                $display("FAIL fill_step%0d: got count=%0d head=%0d flags=%b expected count=%0d head=0 flags=%b",
                         i, bus.word_count, bus.r_data,
                         {bus.empty, bus.full, bus.almost_empty, bus.almost_full}, i + 1, exp_flags);
            end
        end
        // 17th write is dropped
        bus.w_data = 4'd9;
        cyc();
        idle();
        tests++;
        if (bus.word_count !== 6'd16 || bus.full !== 1'b1 || bus.r_data !== 4'd0) begin
            fails++;
            $display("FAIL fill_overflow: got count=%0d full=%b head=%0d expected 16/1/0",
                     bus.word_count, bus.full, bus.r_data);
        end
`ifdef FIFO_ERR_FLAGS_EN
        tests++;
        if (bus.overflow !== 1'b1 || bus.underflow !== 1'b0) begin
            fails++;
            $display("FAIL overflow_flag: got ovf/unf=%b%b expected 10", bus.overflow, bus.underflow);
        end
`endif
    endtask

    task automatic test_drain();
        int bad;
        bad = 0;
        bus.rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (bus.r_data !== 4'(i)) begin
                fails++;
                $display("FAIL drain_data%0d: got %0d expected %0d", i, bus.r_data, i);
            end
            cyc();
        end
        tests++;
        if (bus.empty !== 1'b1 || bus.word_count !== 6'd0 || bus.r_data !== 4'd0) begin
            fails++;
            $display("FAIL drain_empty: got empty=%b count=%0d r_data=%0d expected 1/0/0",
                     bus.empty, bus.word_count, bus.r_data);
        end
        // Extra read while empty
        cyc();
        idle();
        tests++;
        if (bus.empty !== 1'b1 || bus.word_count !== 6'd0 || bus.almost_empty !== 1'b1) begin
            fails++;
            $display("FAIL underflow_state: got empty=%b count=%0d ae=%b expected 1/0/1",
                     bus.empty, bus.word_count, bus.almost_empty);
        end
`ifdef FIFO_ERR_FLAGS_EN
        tests++;
        if (bus.underflow !== 1'b1 || bus.overflow !== 1'b1) begin
            fails++;
            $display("FAIL underflow_flag: got ovf/unf=%b%b expected 11", bus.overflow, bus.underflow);
        end
`endif
    endtask

    task automatic test_wrap();
        logic [3:0] v;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.wr = 1'b1;
            bus.w_data = 4'(10 + i);
            cyc();
        end
        idle();
        bus.rd = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tests++;
            if (bus.r_data !== 4'(10 + i)) begin
                fails++;
                $display("FAIL wrap_pre%0d: got %0d expected %0d", i, bus.r_data, 10 + i);
            end
            cyc();
        end
        idle();
        for (int i = 0; i < 16; i++) begin
            v = 4'((i * 3 + 1) % 16);
            bus.wr = 1'b1;
            bus.w_data = v;
            cyc();
            tests++;
            if (bus.full !== (i == 15)) begin
                fails++;
                $display("FAIL wrap_full%0d: got full=%b expected %b", i, bus.full, (i == 15));
            end
        end
        idle();
        bus.rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            v = 4'((i * 3 + 1) % 16);
            tests++;
            if (bus.r_data !== v) begin
                fails++;
                $display("FAIL wrap_read%0d: got %0d expected %0d", i, bus.r_data, v);
            end
            cyc();
        end
        idle();
        tests++;
        if (bus.empty !== 1'b1) begin
            fails++;
            $display("FAIL wrap_empty: got empty=%b expected 1", bus.empty);
        end
    endtask

    task automatic test_simul();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            bus.wr = 1'b1;
            bus.w_data = 4'(i);
            cyc();
        end
        for (int k = 0; k < 8; k++) begin
            bus.wr = 1'b1;
            bus.rd = 1'b1;
            bus.w_data = 4'(k % 4);
            tests++;
            if (bus.r_data !== 4'(k % 4)) begin
                fails++;
                $display("FAIL simul_head%0d: got %0d expected %0d", k, bus.r_data, k % 4);
            end
            cyc();
            tests++;
            if (bus.word_count !== 6'd4) begin
                fails++;
                $display("FAIL simul_count%0d: got %0d expected 4", k, bus.word_count);
            end
        end
        idle();
        // Contents now 0,1,2,3; top up to full with 4..15
        for (int i = 4; i < 16; i++) begin
            bus.wr = 1'b1;
            bus.w_data = 4'(i);
            cyc();
        end
        bus.wr = 1'b1;
        bus.rd = 1'b1;
        bus.w_data = 4'd7;
        cyc();
        idle();
        tests++;
        if (bus.word_count !== 6'd16 || bus.full !== 1'b1 || bus.r_data !== 4'd1) begin
            fails++;
            $display("FAIL simul_full: got count=%0d full=%b head=%0d expected 16/1/1",
                     bus.word_count, bus.full, bus.r_data);
        end
        bus.rd = 1'b1;
        for (int i = 0; i < 16; i++) begin
            tests++;
            if (bus.r_data !== ((i < 15) ? 4'(i + 1) : 4'd7)) begin
                fails++;
                $display("FAIL simul_full_read%0d: got %0d expected %0d",
                         i, bus.r_data, (i < 15) ? i + 1 : 7);
            end
            cyc();
        end
        // Empty: rd & wr together takes only the write
        bus.wr = 1'b1;
        bus.rd = 1'b1;
        bus.w_data = 4'd5;
        cyc();
        idle();
        tests++;
        if (bus.word_count !== 6'd1 || bus.r_data !== 4'd5 || bus.empty !== 1'b0) begin
            fails++;
            $display("FAIL simul_empty: got count=%0d r_data=%0d empty=%b expected 1/5/0",
                     bus.word_count, bus.r_data, bus.empty);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            bus.wr = 1'b1;
            bus.w_data = 4'(i);
            cyc();
        end
        reset = 1'b1;
        bus.wr = 1'b1;
        bus.w_data = 4'd6;
        cyc();
        reset = 1'b0;
        idle();
        tests++;
        if (bus.word_count !== 6'd0 || bus.empty !== 1'b1 || bus.r_data !== 4'd0) begin
            fails++;
            $display("FAIL reset_mid: got count=%0d empty=%b r_data=%0d expected 0/1/0",
                     bus.word_count, bus.empty, bus.r_data);
        end
        bus.wr = 1'b1;
        bus.w_data = 4'd3;
        cyc();
        idle();
        tests++;
        if (bus.word_count !== 6'd1 || bus.r_data !== 4'd3) begin
            fails++;
            $display("FAIL reset_mid_write: got count=%0d r_data=%0d expected 1/3",
                     bus.word_count, bus.r_data);
        end
    endtask

    initial begin
        tests = 0;
        fails = 0;
        reset = 1'b0;
        idle();
        #2;
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simul();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sync_fifo.md
Name: sync_fifo

Overview:
- Single-clock synchronous FIFO with 2^ADDR_WIDTH entries of DATA_WIDTH bits each.
- Provides full, empty, almost_full and almost_empty flags, plus an occupancy count.
- Used as a generic rate-decoupling buffer between producer and consumer logic in the same clock domain.
- Read data is first-word-fall-through: the oldest word is always visible on r_data.

Parameters:
- DATA_WIDTH, 8, width of each stored word in bits.
- ADDR_WIDTH, 4, pointer width; DEPTH = 2^ADDR_WIDTH entries.
- ALMOST_EMPTY_THRESH, 1, almost_empty asserts when count <= this value.
- ALMOST_FULL_THRESH, 2^ADDR_WIDTH-1, almost_full asserts when count >= this value.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- wr  input  1  write request; pushes w_data.
- w_data  input  DATA_WIDTH  write data.
- rd  input  1  read request; pops the head entry.
- r_data  output  DATA_WIDTH  current head entry.
- empty  output  1  count == 0.
- full  output  1  count == DEPTH.
- almost_empty  output  1  count <= ALMOST_EMPTY_THRESH.
- almost_full  output  1  count >= ALMOST_FULL_THRESH.
- word_count  output  ADDR_WIDTH+2  number of stored words, 0..DEPTH, zero-extended.

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset: on a rising edge with reset=1:
  - write pointer, read pointer and count clear to 0.
  - Next cycle outputs: empty=1, full=0, almost_empty=1, almost_full=0, word_count=0, r_data=0.
  - Memory contents are not cleared.
  - reset overrides wr and rd, and applies mid-operation; all stored data is discarded.
- Storage: DEPTH-entry array; ADDR_WIDTH-bit pointers wrap naturally from DEPTH-1 to 0.
- Write accepted = wr & (~full | rd):
  - mem[wptr] <= w_data; wptr increments.
- Read accepted = rd & ~empty:
  - rptr increments.
- Illegal requests: a write when full with no read is ignored (data dropped, no state change). A read when empty is ignored.
- Simultaneous wr & rd:
  - Not empty (including full): both are accepted and count is unchanged.
  - Empty: only the write is accepted and count increments.
- Count: +1 on accepted write only, -1 on accepted read only, else unchanged. Count is held in a register.
- Flags and word_count are decoded combinationally from the count register, so they update the cycle after the causing edge.
- r_data:
  - Combinational mem[rptr] when not empty, 0 when empty.
  - A word written at edge N appears on r_data after edge N if the FIFO was empty.
  - Read latency is 0 cycles (first-word-fall-through): rd acknowledges the word currently shown, and the next word appears after the edge.
- Ordering: strict first-in first-out order across pointer wrap-around.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- When defined, two additional outputs are added:
  - overflow (1 bit): sticky; set on the edge after a write request is dropped because the FIFO is full.
  - underflow (1 bit): sticky; set on the edge after a read request arrives while empty.
  - Both clear only on reset.
- When not defined, the ports and logic are absent and dropped requests are silent.

Test Plan:
All scenarios use DATA_WIDTH=4, ADDR_WIDTH=4 (DEPTH=16).
1. Reset check: assert reset for 1 cycle -> empty=1, almost_empty=1, full=0, almost_full=0, word_count=0, r_data=0.
2. Fill: write values 0..15 on 16 consecutive cycles -> word_count steps 1..16; almost_empty drops after count reaches 2; almost_full=1 at count 15; full=1 at count 16.
   - A 17th write of 9 is dropped: word_count stays 16 and overflow=1 if FIFO_ERR_FLAGS_EN.
3. Drain: hold rd for 16 cycles -> r_data sequence 0,1,...,15; empty=1 and word_count=0 afterwards.
   - A further rd leaves the state unchanged and sets underflow=1 if FIFO_ERR_FLAGS_EN.
4. Wrap-around: write 4 words, read 4 words, write 16 words (pointers wrap) -> all 16 read back in order; full asserted exactly at 16.
5. Simultaneous rd & wr:
   - Write 0,1,2,3, then assert rd and wr together with data 0..3 -> word_count holds at 4 and r_data shows 0,1,2,3,0,...
   - With the FIFO full, rd&wr keeps count at 16 and accepts the new word.
   - With the FIFO empty, rd&wr gives count 1.
6. Reset mid-operation: after 5 writes, assert reset with wr=1 on the same edge -> word_count=0, empty=1, and the write is not stored.
